// File: rtl/pc_sequencer_if.sv
// Sequencer-side bundle: instruction fields, ALU flags and current PC in,
// PC write side and per-phase datapath strobes out.
interface pc_sequencer_if;
   logic [31:0] cur_pc;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [15:0] imm;
   logic [25:0] jaddr;
   logic [31:0] rs_data;
   logic        zero;
   logic        sign;
   logic        PCWre;
   logic [31:0] PCnext;
   logic        IRWre;
   logic        MemWre;
   logic        RegWre;
   logic [2:0]  state;

   modport master (
      input  cur_pc, opcode, funct, imm, jaddr, rs_data, zero, sign,
      output PCWre, PCnext, IRWre, MemWre, RegWre, state
   );

   modport slave (
      output cur_pc, opcode, funct, imm, jaddr, rs_data, zero, sign,
      input  PCWre, PCnext, IRWre, MemWre, RegWre, state
   );
endinterface

// File: rtl/pc_sequencer.sv
// Multicycle IF/ID/EXE/MEM/WB control sequencer driving the PC write side
// and the per-phase IR / data memory / register file write strobes.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [5:0]  HALT_OP  = 6'b111111
) (
   input  logic           CLK,
   input  logic           Reset,
   pc_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EXE  = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_HALT = 3'd5
   } state_t;

   typedef enum logic [3:0] {
      C_R, C_ALUI, C_LW, C_SW, C_BEQ, C_BNE, C_BLTZ, C_J, C_JAL, C_JR, C_HALT
   } cls_t;

   state_t             st;
   logic [5:0]         op_q;
   logic [5:0]         funct_q;
   logic [15:0]        imm_q;
   cls_t               cls;
   logic [31:0]        pc4;
   logic signed [31:0] br_off;
   logic               taken;

   function automatic cls_t decode(input logic [5:0] op, input logic [5:0] fn);
      cls_t c;
      c = C_R;
      if (op == HALT_OP) begin
         c = C_HALT;
      end else begin
         case (op)
            6'b000000: c = (fn == 6'b001000) ? C_JR : C_R;
            6'b001000: c = C_ALUI;
            6'b001101: c = C_ALUI;
            6'b100011: c = C_LW;
            6'b101011: c = C_SW;
            6'b000100: c = C_BEQ;
            6'b000101: c = C_BNE;
            6'b000001: c = C_BLTZ;
            6'b000010: c = C_J;
            6'b000011: c = C_JAL;
            default:   c = C_R;
         endcase
      end
      return c;
   endfunction

   // ID decides from the live IR; every later state works from the latched copy.
   assign cls    = (st == S_ID) ? decode(bus.opcode, bus.funct) : decode(op_q, funct_q);
   assign pc4    = bus.cur_pc + 32'd4;
   assign br_off = signed'({{14{imm_q[15]}}, imm_q, 2'b00});

   always_comb begin
      taken = 1'b0;
      case (cls)
         C_BEQ:   taken = bus.zero;
         C_BNE:   taken = ~bus.zero;
         C_BLTZ:  taken = bus.sign;
         default: taken = 1'b0;
      endcase
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         st      <= S_IF;
         op_q    <= 6'd0;
         funct_q <= 6'd0;
      end else begin
         case (st)
            S_IF: st <= S_ID;
            S_ID: begin
               op_q    <= bus.opcode;
               funct_q <= bus.funct;
               case (cls)
                  C_J, C_JAL, C_JR: st <= S_IF;
                  C_HALT:           st <= S_HALT;
                  default:          st <= S_EXE;
               endcase
            end
            S_EXE: begin
               case (cls)
                  C_BEQ, C_BNE, C_BLTZ: st <= S_IF;
                  C_LW, C_SW:           st <= S_MEM;
                  default:              st <= S_WB;
               endcase
            end
            S_MEM:   st <= (cls == C_SW) ? S_IF : S_WB;
            S_WB:    st <= S_IF;
            S_HALT:  st <= S_HALT;
            default: st <= S_IF;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (st == S_ID) imm_q <= bus.imm;
   end

   always_comb begin
      bus.PCnext = pc4;
      if (Reset)
         bus.PCnext = RESET_PC;
      else if (st == S_ID && (cls == C_J || cls == C_JAL))
         bus.PCnext = {pc4[31:28], bus.jaddr, 2'b00};
      else if (st == S_ID && cls == C_JR)
         bus.PCnext = bus.rs_data;
      else if (st == S_EXE && taken)
         bus.PCnext = pc4 + $unsigned(br_off);
   end

   // Strobes are forced low while Reset is held, even though st already reads IF.
   always_comb begin
      bus.PCWre  = 1'b0;
      bus.IRWre  = 1'b0;
      bus.MemWre = 1'b0;
      bus.RegWre = 1'b0;
      if (!Reset) begin
         case (st)
            S_IF: bus.IRWre = 1'b1;
            S_ID: begin
               bus.PCWre  = (cls == C_J) || (cls == C_JAL) || (cls == C_JR);
               bus.RegWre = (cls == C_JAL);
            end
            S_EXE: bus.PCWre = (cls == C_BEQ) || (cls == C_BNE) || (cls == C_BLTZ);
            S_MEM: begin
               bus.PCWre  = (cls == C_SW);
               bus.MemWre = (cls == C_SW);
            end
            S_WB: begin
               bus.PCWre  = 1'b1;
               bus.RegWre = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.state = st;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multicycle control sequencer that drives the PC register's write side: generates PCWre and PCnext, and steps each instruction through IF/ID/EXE/MEM/WB.
- Sits between the instruction register / ALU flags and the PC register.
- Consumes the current PC and issues the next one.
- Also emits the per-phase write strobes (IRWre, MemWre, RegWre) so the datapath commits in the correct cycle.

Parameters:
- RESET_PC, 32'h0000_0000, value driven on PCnext while Reset is high so the PC loads a defined start address.
- HALT_OP, 6'b111111, opcode that parks the sequencer in HALT.

Ports:
- CLK  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high reset
- cur_pc  input  32  current PC register value
- opcode  input  6  IR[31:26], valid from ID onward
- funct  input  6  IR[5:0]
- imm  input  16  IR[15:0], branch offset in words
- jaddr  input  26  IR[25:0]
- rs_data  input  32  register-file rs read data (jr target)
- zero  input  1  ALU zero flag, valid in EXE
- sign  input  1  ALU result sign flag, valid in EXE
- PCWre  output  1  PC write enable, one pulse per instruction
- PCnext  output  32  next PC value
- IRWre  output  1  instruction register load, high in IF
- MemWre  output  1  data memory write, sw only, in MEM
- RegWre  output  1  register-file write, in WB or jal ID
- state  output  3  IF=0, ID=1, EXE=2, MEM=3, WB=4, HALT=5

Behaviour:
- Reset (async, any cycle, including mid-instruction):
  - state=IF; latched class cleared.
  - PCWre=0, IRWre=0, MemWre=0, RegWre=0, PCnext=RESET_PC.
- After Reset deasserts, the first clock edge is spent in IF. IRWre=1 in IF.
- ID: latch opcode, funct and imm into internal registers on the ID edge. Later states use only the latched copies.
- Class decode (MIPS encoding):
  - R-type: 000000, except funct 001000, which is jr.
  - ALU-immediate: addi 001000, ori 001101.
  - lw 100011, sw 101011.
  - Branches: beq 000100, bne 000101, bltz 000001.
  - Jumps: j 000010, jal 000011.
  - HALT_OP.
  - Any other opcode follows the R-type path.
- Transitions:
  - IF -> ID always.
  - ID -> IF for j, jal, jr.
  - ID -> HALT for halt.
  - ID -> EXE for all others.
  - EXE -> IF for branches.
  - EXE -> MEM for lw/sw.
  - EXE -> WB for R-type and ALU-immediate.
  - MEM -> WB for lw; MEM -> IF for sw.
  - WB -> IF.
  - HALT -> HALT until Reset.
- PCWre=1 for exactly one cycle, in the last state of each instruction:
  - ID for j/jal/jr.
  - EXE for branches.
  - MEM for sw.
  - WB for everything else.
- PCWre is never asserted in HALT. The PC holds.
- PCnext is combinational. pc4 = cur_pc + 32'd4 (wraps modulo 2^32).
  - Default: pc4.
  - Taken branch: pc4 + ({{14{imm[15]}}, imm, 2'b00}), wrapping. Taken conditions: beq when zero=1; bne when zero=0; bltz when sign=1.
  - j/jal: {pc4[31:28], jaddr, 2'b00}.
  - jr: rs_data, passed unmodified (no alignment check).
- MemWre=1 only in MEM for sw.
- RegWre=1:
  - in WB for R-type, ALU-immediate and lw;
  - in ID for jal (datapath writes pc4 to $31);
  - never for jr, j, branches, sw or halt.
- Flags zero and sign are sampled only in EXE; their values in other states are ignored.
- Latency in cycles, IF to PC update:
  - j/jal/jr: 2.
  - Branch: 3.
  - R-type/ALU-immediate and sw: 4.
  - lw: 5.

Test Plan:
- Reset high 3 cycles, then release, cur_pc=0 -> state=IF, PCnext=0 during reset; IRWre=1 next cycle, PCWre=0 throughout.
- R-type add, cur_pc=0x0000_0010 -> states 0,1,2,4; PCWre=1 only in WB; RegWre=1 in WB; PCnext=0x0000_0014.
- beq, imm=16'hFFFE, zero=1, cur_pc=0x100 -> PCWre in EXE, PCnext=0x0000_00FC. With zero=0 -> PCnext=0x104.
- lw, then sw, at cur_pc=0x20:
  - lw: 5 cycles, RegWre in WB, MemWre=0.
  - sw: 4 cycles, MemWre=1 in MEM only, PCnext=0x24.
- j jaddr=26'h000_0040, cur_pc=0xF000_0000 -> PCWre in ID, PCnext=0xF000_0100.
- jal -> same timing as j, RegWre=1 in ID.
- jr with rs_data=0x1234_5678 -> PCnext=0x1234_5678.
- halt -> state=5 held for 20 cycles, PCWre=0.
- Reset asserted mid-EXE of a branch -> immediate state=IF, all strobes 0.
